// File: rtl/mcb_write_port_arbiter.sv
// Purpose: shares one MCB write port (command FIFO + write-data FIFO) between two
//          burst requesters, granting whole bursts round-robin; requester 0 wins
//          first after reset.
// Latency: Grant rises one edge after a sampled request. Words pass
//          combinationally to the write-data FIFO. The command issues in the
//          cycle after the last word, or later if the command FIFO is full.
// Backpressure: wr_full drops DataReadyN without losing words. write_cmd_full
//          holds the burst in CMD until the command can be pushed.
//
// Ports:
//   Clk, Rst                 single clock, synchronous active-high reset
//   calib_done               gates new grants only
//   ReqN/ReqAddrN/ReqBLN     burst request, byte address, length-1 (N = 0,1)
//   DataN/MaskN/DataValidN   write word stream from requester N
//   GrantN/DataReadyN/DoneN  ownership, word accept, command-issued pulse
//   Error                    sticky fault (MCB underrun/error, clamped BL)
//   write_cmd_*              MCB command FIFO side
//   wr_*                     MCB write-data FIFO side
module mcb_write_port_arbiter #(
    parameter int          AddrWidth        = 30,
    parameter logic [2:0]  WriteInstruction = 3'b000,
    parameter int          MaxBurstLength   = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 calib_done,

    input  logic                 Req0,
    input  logic [AddrWidth-1:0] ReqAddr0,
    input  logic [5:0]           ReqBL0,
    input  logic [31:0]          Data0,
    input  logic [3:0]           Mask0,
    input  logic                 DataValid0,

    input  logic                 Req1,
    input  logic [AddrWidth-1:0] ReqAddr1,
    input  logic [5:0]           ReqBL1,
    input  logic [31:0]          Data1,
    input  logic [3:0]           Mask1,
    input  logic                 DataValid1,

    output logic                 Grant0,
    output logic                 Grant1,
    output logic                 DataReady0,
    output logic                 DataReady1,
    output logic                 Done0,
    output logic                 Done1,
    output logic                 Error,

    output logic                 write_cmd_clk,
    output logic                 write_cmd_en,
    output logic [2:0]           write_cmd_instr,
    output logic [5:0]           write_cmd_bl,
    output logic [AddrWidth-1:0] write_cmd_byte_addr,
    input  logic                 write_cmd_full,

    output logic                 wr_clk,
    output logic                 wr_en,
    output logic [3:0]           wr_mask,
    output logic [31:0]          wr_data,
    input  logic                 wr_full,
    input  logic                 wr_underrun,
    input  logic                 wr_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CMD  = 2'd2
    } state_t;

    // Largest BL value the write-data FIFO can hold.
    localparam int          MaxBlInt = MaxBurstLength - 1;
    localparam logic [5:0]  MaxBl    = MaxBlInt[5:0];
    localparam bit          ClampOn  = (MaxBurstLength < 64);

    state_t               state;
    state_t               state_nxt;

    logic                 owner;        // index of the requester holding the port
    logic                 last_grant;   // index granted most recently
    logic [AddrWidth-1:0] addr_q;
    logic [5:0]           bl_q;
    logic [5:0]           cnt;          // words accepted so far in this burst
    logic                 error_q;

    // FSM strobes into the datapath.
    logic                 take;
    logic                 win;
    logic                 accept;
    logic                 cmd_issue;

    // Request fields of the winner, used only on the grant edge.
    logic [AddrWidth-1:0] win_addr;
    logic [5:0]           win_bl_raw;
    logic                 win_bl_over;
    logic [5:0]           win_bl;

    logic                 data_ready;
    logic                 sel_valid;

    // ---------------------------------------------------------------
    // Shared combinational views
    // ---------------------------------------------------------------
    assign data_ready = (state == DATA) && !wr_full;
    assign sel_valid  = owner ? DataValid1 : DataValid0;

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    assign win        = Req1 && (!Req0 || (last_grant == 1'b0));

    assign win_addr    = win ? ReqAddr1 : ReqAddr0;
    assign win_bl_raw  = win ? ReqBL1 : ReqBL0;
    assign win_bl_over = ClampOn && (win_bl_raw > MaxBl);
    assign win_bl      = win_bl_over ? MaxBl : win_bl_raw;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state and strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        accept    = 1'b0;
        cmd_issue = 1'b0;

        case (state)
            IDLE: begin
                // calib_done only gates new grants; a burst in flight finishes.
                if (calib_done && (Req0 || Req1)) begin
                    take      = 1'b1;
                    state_nxt = DATA;
                end
            end

            DATA: begin
                accept = data_ready && sel_valid;
                // Compare before incrementing so BL = 63 finishes at cnt = 63
                // and the 6-bit counter never needs to hold 64.
                if (accept && (cnt == bl_q)) begin
                    state_nxt = CMD;
                end
            end

            CMD: begin
                if (!write_cmd_full) begin
                    cmd_issue = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Burst datapath: owner, latched command fields, word counter, Error
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            bl_q       <= '0;
            cnt        <= '0;
            error_q    <= 1'b0;
        end else begin
            if (take) begin
                owner      <= win;
                last_grant <= win;
                // MCB addresses are word aligned; drop the byte offset.
                addr_q     <= {win_addr[AddrWidth-1:2], 2'b00};
                bl_q       <= win_bl;
                cnt        <= '0;
            end else if (accept) begin
                cnt <= cnt + 6'd1;
            end

            if (wr_underrun || wr_error || (take && win_bl_over)) begin
                error_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Requester-side outputs
    // ---------------------------------------------------------------
    // Ownership spans DATA and CMD, so GrantN is still high in the Done cycle.
    assign Grant0     = (state != IDLE) && !owner;
    assign Grant1     = (state != IDLE) &&  owner;
    assign DataReady0 = data_ready && !owner;
    assign DataReady1 = data_ready &&  owner;
    assign Done0      = cmd_issue && !owner;
    assign Done1      = cmd_issue &&  owner;
    assign Error      = error_q;

    // ---------------------------------------------------------------
    // MCB-side outputs
    // ---------------------------------------------------------------
    assign write_cmd_clk       = Clk;
    assign write_cmd_en        = cmd_issue;
    assign write_cmd_instr     = WriteInstruction;
    assign write_cmd_bl        = bl_q;
    assign write_cmd_byte_addr = addr_q;

    assign wr_clk  = Clk;
    assign wr_en   = accept;
    assign wr_data = Grant0 ? Data0 : (Grant1 ? Data1 : 32'h0);
    assign wr_mask = Grant0 ? Mask0 : (Grant1 ? Mask1 : 4'h0);

endmodule

// File: tb/tb_mcb_write_port_arbiter.sv
// Purpose: directed self-checking bench for mcb_write_port_arbiter.
// Latency: inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
// Backpressure: wr_full and write_cmd_full are driven directly from the stimulus.
module tb_mcb_write_port_arbiter;

    localparam int AW = 30;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          calib_done;
    logic          Req0, Req1;
    logic [AW-1:0] ReqAddr0, ReqAddr1;
    logic [5:0]    ReqBL0, ReqBL1;
    logic [31:0]   Data0, Data1;
    logic [3:0]    Mask0, Mask1;
    logic          DataValid0, DataValid1;
    logic          Grant0, Grant1, DataReady0, DataReady1, Done0, Done1, Error;
    logic          write_cmd_clk, write_cmd_en;
    logic [2:0]    write_cmd_instr;
    logic [5:0]    write_cmd_bl;
    logic [AW-1:0] write_cmd_byte_addr;
    logic          write_cmd_full;
    logic          wr_clk, wr_en;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;
    logic          wr_full, wr_underrun, wr_error;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mcb_write_port_arbiter #(
        .AddrWidth(AW), .WriteInstruction(3'b000), .MaxBurstLength(64)
    ) dut (
        .Clk(Clk), .Rst(Rst), .calib_done(calib_done),
        .Req0(Req0), .ReqAddr0(ReqAddr0), .ReqBL0(ReqBL0), .Data0(Data0),
        .Mask0(Mask0), .DataValid0(DataValid0),
        .Req1(Req1), .ReqAddr1(ReqAddr1), .ReqBL1(ReqBL1), .Data1(Data1),
        .Mask1(Mask1), .DataValid1(DataValid1),
        .Grant0(Grant0), .Grant1(Grant1), .DataReady0(DataReady0),
        .DataReady1(DataReady1), .Done0(Done0), .Done1(Done1), .Error(Error),
        .write_cmd_clk(write_cmd_clk), .write_cmd_en(write_cmd_en),
        .write_cmd_instr(write_cmd_instr), .write_cmd_bl(write_cmd_bl),
        .write_cmd_byte_addr(write_cmd_byte_addr), .write_cmd_full(write_cmd_full),
        .wr_clk(wr_clk), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_full(wr_full), .wr_underrun(wr_underrun), .wr_error(wr_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs may be changed right after this returns.
    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        int gcount;
        int w;
        int pushes;
        logic exp_n;

        Rst = 1'b1; calib_done = 1'b0;
        Req0 = 1'b0; Req1 = 1'b0;
        ReqAddr0 = '0; ReqAddr1 = '0; ReqBL0 = '0; ReqBL1 = '0;
        Data0 = '0; Data1 = '0; Mask0 = '0; Mask1 = '0;
        DataValid0 = 1'b0; DataValid1 = 1'b0;
        write_cmd_full = 1'b0; wr_full = 1'b0; wr_underrun = 1'b0; wr_error = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        #1;
        chk("rst_grant", {Grant1, Grant0}, 2'b00);
        chk("rst_cmd_en", write_cmd_en, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_error", Error, 1'b0);
        chk("rst_bl", write_cmd_bl, 6'd0);
        chk("rst_addr", write_cmd_byte_addr, 30'd0);
        chk("rst_instr", write_cmd_instr, 3'b000);
        chk("rst_done", {Done1, Done0}, 2'b00);
        chk("rst_wr_clk", wr_clk, Clk);
        Rst = 1'b0;

        // ---------------- calib_done gating ----------------
        Req0 = 1'b1; ReqAddr0 = 30'h12C01; ReqBL0 = 6'd3;
        gcount = 0;
        for (int i = 0; i < 20; i++) begin
            step(); #1;
            if (Grant0 || Grant1) gcount++;
        end
        chk("calib_no_grant", gcount, 0);
        calib_done = 1'b1;
        #1;
        chk("calib_same_cycle", Grant0, 1'b0);
        step(); #1;
        chk("calib_grant0", {Grant1, Grant0}, 2'b01);

        // ---------------- single burst BL=3 ----------------
        for (int i = 0; i < 4; i++) begin
            Data0 = 32'hA0 + i; Mask0 = 4'(i + 1); DataValid0 = 1'b1;
            #1;
            chk("b0_ready", DataReady0, 1'b1);
            chk("b0_wr_en", wr_en, 1'b1);
            chk("b0_wr_data", wr_data, 32'hA0 + i);
            chk("b0_wr_mask", wr_mask, 4'(i + 1));
            chk("b0_no_cmd", write_cmd_en, 1'b0);
            step();
        end
        DataValid0 = 1'b0;
        #1;
        chk("b0_cmd_en", write_cmd_en, 1'b1);
        chk("b0_cmd_addr", write_cmd_byte_addr, 30'h12C00);
        chk("b0_cmd_bl", write_cmd_bl, 6'd3);
        chk("b0_cmd_instr", write_cmd_instr, 3'b000);
        chk("b0_done", {Done1, Done0}, 2'b01);
        chk("b0_cmd_no_wr", wr_en, 1'b0);
        Req0 = 1'b0;
        step(); #1;
        chk("b0_idle_grant", {Grant1, Grant0}, 2'b00);
        chk("b0_done_pulse", {Done1, Done0}, 2'b00);
        chk("b0_cmd_once", write_cmd_en, 1'b0);

        // ---------------- round-robin, BL=0 each ----------------
        // Requester 0 was granted last, so requester 1 goes first here.
        Req0 = 1'b1; Req1 = 1'b1; ReqBL0 = 6'd0; ReqBL1 = 6'd0;
        ReqAddr0 = 30'h100; ReqAddr1 = 30'h203;
        Data0 = 32'h11110000; Data1 = 32'h22220000;
        DataValid0 = 1'b1; DataValid1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_n = (k % 2 == 0);
            step(); #1;
            chk("rr_grant", {Grant1, Grant0}, exp_n ? 2'b10 : 2'b01);
            chk("rr_wr_en", wr_en, 1'b1);
            chk("rr_wr_data", wr_data, exp_n ? 32'h22220000 : 32'h11110000);
            step(); #1;
            chk("rr_cmd_en", write_cmd_en, 1'b1);
            chk("rr_done", {Done1, Done0}, exp_n ? 2'b10 : 2'b01);
            chk("rr_addr", write_cmd_byte_addr, exp_n ? 30'h200 : 30'h100);
            chk("rr_cmd_no_wr", wr_en, 1'b0);
            if (k == 3) begin
                Req0 = 1'b0; Req1 = 1'b0; DataValid0 = 1'b0; DataValid1 = 1'b0;
            end
            step(); #1;
            chk("rr_idle_gap", {Grant1, Grant0}, 2'b00);
        end

        // ---------------- wr_full stall, BL=7, then write_cmd_full ----------------
        Req1 = 1'b1; ReqAddr1 = 30'h400; ReqBL1 = 6'd7;
        step();
        w = 0; pushes = 0;
        for (int c = 0; c < 30 && w < 8; c++) begin
            wr_full = (c >= 3 && c < 8);
            Data1 = 32'hB000 + w; Mask1 = 4'hF; DataValid1 = 1'b1;
            #1;
            chk("st_ready", DataReady1, !wr_full);
            chk("st_cmd_early", write_cmd_en, 1'b0);
            if (wr_en) begin
                chk("st_wr_data", wr_data, 32'hB000 + w);
                w++; pushes++;
            end
            step();
        end
        wr_full = 1'b0; DataValid1 = 1'b0;
        chk("st_words", pushes, 8);
        write_cmd_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("cf_hold_en", write_cmd_en, 1'b0);
            chk("cf_hold_done", Done1, 1'b0);
            chk("cf_hold_grant", Grant1, 1'b1);
            step();
        end
        write_cmd_full = 1'b0;
        #1;
        chk("cf_cmd_en", write_cmd_en, 1'b1);
        chk("cf_done", {Done1, Done0}, 2'b10);
        chk("cf_bl", write_cmd_bl, 6'd7);
        chk("cf_addr", write_cmd_byte_addr, 30'h400);
        Req1 = 1'b0;
        step(); #1;
        chk("cf_after_en", write_cmd_en, 1'b0);
        chk("cf_after_grant", Grant1, 1'b0);

        // ---------------- BL=63: 64 words, no early wrap ----------------
        Req0 = 1'b1; ReqAddr0 = 30'h8000; ReqBL0 = 6'd63;
        step();
        w = 0;
        for (int c = 0; c < 100; c++) begin
            Data0 = 32'hC0000000 + w; DataValid0 = 1'b1;
            #1;
            if (write_cmd_en) break;
            if (wr_en) begin
                chk("bl63_data", wr_data, 32'hC0000000 + w);
                w++;
            end
            step();
        end
        chk("bl63_words", w, 64);
        chk("bl63_cmd_en", write_cmd_en, 1'b1);
        chk("bl63_bl", write_cmd_bl, 6'd63);
        Req0 = 1'b0; DataValid0 = 1'b0;
        step();

        // ---------------- sticky Error ----------------
        wr_error = 1'b1;
        step(); wr_error = 1'b0; #1;
        chk("err_set", Error, 1'b1);
        Req0 = 1'b1; ReqBL0 = 6'd0; Data0 = 32'h5; DataValid0 = 1'b1;
        step(); step(); #1;
        chk("err_burst_cmd", write_cmd_en, 1'b1);
        Req0 = 1'b0;
        step(); step(); #1;
        chk("err_sticky", Error, 1'b1);

        // ---------------- reset during DATA ----------------
        Req0 = 1'b1; ReqAddr0 = 30'h777; ReqBL0 = 6'd5;
        step(); #1;
        chk("rd_grant", Grant0, 1'b1);
        Rst = 1'b1;
        step(); #1;
        chk("rd_grant_clr", {Grant1, Grant0}, 2'b00);
        chk("rd_ready_clr", DataReady0, 1'b0);
        chk("rd_wr_en_clr", wr_en, 1'b0);
        chk("rd_error_clr", Error, 1'b0);
        chk("rd_bl_clr", write_cmd_bl, 6'd0);
        chk("rd_addr_clr", write_cmd_byte_addr, 30'd0);
        chk("rd_wr_data_clr", wr_data, 32'd0);
        Rst = 1'b0; Req0 = 1'b0; DataValid0 = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
